// File: rtl/vreg_port_arbiter_pkg.sv
// Shared types for the vector register file port arbiter.
// Requester ids, operation class and controller state encodings live here.
package vreg_port_arbiter_pkg;

    localparam int ARB_NUM_REQ = 4;
    localparam int ARB_ID_W    = $clog2(ARB_NUM_REQ);

    typedef enum logic {
        ARB_RD = 1'b0,
        ARB_WR = 1'b1
    } arb_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        STALL = 2'd2
    } arb_state_e;

    typedef logic [ARB_ID_W-1:0] req_id_t;

    // Round-robin successor of a requester id, wrapping at the last requester.
    function automatic req_id_t next_id(input req_id_t id);
        if (id == req_id_t'(ARB_NUM_REQ - 1)) begin
            return '0;
        end
        return id + 1'b1;
    endfunction

endpackage

// File: rtl/vreg_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of mask at or after ptr,
// wrapping from N-1 back to 0.
module vreg_port_arbiter_rr_pick
    import vreg_port_arbiter_pkg::*;
#(
    parameter int N    = ARB_NUM_REQ,
    parameter int ID_W = ARB_ID_W
) (
    input  logic [N-1:0]    mask,
    input  logic [ID_W-1:0] ptr,
    output logic            found,
    output logic [ID_W-1:0] idx
);

    logic [2*N-1:0]  doubled;
    logic [N-1:0]    rotated;
    logic [ID_W-1:0] offset;
    logic [ID_W:0]   sum;

    // Rotate so ptr lands on bit 0; the lowest set bit is then the winner's distance from ptr.
    always_comb begin
        doubled = {mask, mask} >> ptr;
        rotated = doubled[N-1:0];
        found   = 1'b0;
        offset  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                found  = 1'b1;
                offset = ID_W'(k);
            end
        end
        sum = {1'b0, ptr} + {1'b0, offset};
        if (sum >= (ID_W + 1)'(N)) begin
            sum = sum - (ID_W + 1)'(N);
        end
        idx = sum[ID_W-1:0];
    end

endmodule

// File: rtl/vreg_port_arbiter.sv
// Shares one vector register file port among NUM_REQ requesters with round-robin grant
// and in-order read response routing. Define VREG_ARB_WR_PRIO_EN for write priority.
module vreg_port_arbiter
    import vreg_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = ARB_NUM_REQ,
    parameter int DATA_W     = 64,
    parameter int IDX_W      = 5,
    parameter int MAX_OUT    = 4,
    parameter int STARVE_LIM = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_vld,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*IDX_W-1:0]  req_idx,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_grant,
    output logic [NUM_REQ-1:0]        rsp_vld,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rf_vld,
    output logic                      rf_we,
    output logic [IDX_W-1:0]          rf_idx,
    output logic [DATA_W-1:0]         rf_wdata,
    input  logic                      rf_ready,
    input  logic                      rf_rsp_vld,
    input  logic [DATA_W-1:0]         rf_rsp_data,
    output logic                      err_orphan
);

    localparam int PTR_W = $clog2(MAX_OUT);
    localparam int CNT_W = PTR_W + 1;

    if (NUM_REQ != ARB_NUM_REQ || (1 << PTR_W) != MAX_OUT || STARVE_LIM < 1) begin : g_param_check
        $error("vreg_port_arbiter: unsupported parameterisation");
    end

    req_id_t             rr_ptr;
    req_id_t             tag_mem [MAX_OUT];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;
    arb_state_e          state;

    logic                rd_blocked;
    logic [NUM_REQ-1:0]  elig;
    logic                any_elig;
    req_id_t             winner;
    logic                grant_fire;
    arb_op_e             win_op;
    logic                push;
    logic                pop;

    // A response popping this cycle frees a slot, so a full FIFO only blocks reads without one.
    assign rd_blocked = (count == CNT_W'(MAX_OUT)) && !rf_rsp_vld;
    assign elig       = reset ? '0 : (req_vld & (req_we | {NUM_REQ{!rd_blocked}}));

`ifdef VREG_ARB_WR_PRIO_EN
    localparam int STARVE_W = $clog2(STARVE_LIM + 1);

    logic [STARVE_W-1:0] starve_cnt;
    logic [NUM_REQ-1:0]  rd_mask;
    logic [NUM_REQ-1:0]  wr_mask;
    logic                rd_found;
    logic                wr_found;
    req_id_t             rd_pick;
    req_id_t             wr_pick;
    logic                read_force;

    assign rd_mask = elig & ~req_we;
    assign wr_mask = elig & req_we;

    vreg_port_arbiter_rr_pick #(.N(NUM_REQ), .ID_W(ARB_ID_W)) u_rd_pick (
        .mask  (rd_mask),
        .ptr   (rr_ptr),
        .found (rd_found),
        .idx   (rd_pick)
    );

    vreg_port_arbiter_rr_pick #(.N(NUM_REQ), .ID_W(ARB_ID_W)) u_wr_pick (
        .mask  (wr_mask),
        .ptr   (rr_ptr),
        .found (wr_found),
        .idx   (wr_pick)
    );

    assign read_force = (starve_cnt == STARVE_W'(STARVE_LIM)) && rd_found;
    assign winner     = (wr_found && !read_force) ? wr_pick : rd_pick;
    assign any_elig   = rd_found | wr_found;

    // Counts write grants taken while a read was waiting; any read grant resets it.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (grant_fire) begin
            if (win_op == ARB_RD) begin
                starve_cnt <= '0;
            end else if (rd_found && starve_cnt != STARVE_W'(STARVE_LIM)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end
`else
    vreg_port_arbiter_rr_pick #(.N(NUM_REQ), .ID_W(ARB_ID_W)) u_pick (
        .mask  (elig),
        .ptr   (rr_ptr),
        .found (any_elig),
        .idx   (winner)
    );
`endif

    always_comb begin
        rf_we    = 1'b0;
        rf_idx   = '0;
        rf_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == req_id_t'(i)) begin
                rf_we    = req_we[i];
                rf_idx   = req_idx[i*IDX_W +: IDX_W];
                rf_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign rf_vld     = any_elig;
    assign grant_fire = any_elig & rf_ready;
    assign win_op     = rf_we ? ARB_WR : ARB_RD;
    assign push       = grant_fire && (win_op == ARB_RD);
    assign pop        = rf_rsp_vld && (count != '0);

    always_comb begin
        req_grant = '0;
        if (grant_fire) begin
            req_grant[winner] = 1'b1;
        end
    end

    // Tag FIFO records which requester owns each outstanding read; responses return in order.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            rsp_vld    <= '0;
            rsp_data   <= '0;
            err_orphan <= 1'b0;
        end else begin
            if (grant_fire) begin
                rr_ptr <= next_id(winner);
            end
            if (push) begin
                tag_mem[wr_ptr] <= winner;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            rsp_vld <= '0;
            if (pop) begin
                rsp_vld[tag_mem[rd_ptr]] <= 1'b1;
                rsp_data                 <= rf_rsp_data;
                rd_ptr                   <= rd_ptr + 1'b1;
            end else if (rf_rsp_vld) begin
                err_orphan <= 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Debug-only controller state; the winner is recomputed every cycle so STALL never locks.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else if (!any_elig) begin
            state <= IDLE;
        end else if (rf_ready) begin
            state <= ISSUE;
        end else begin
            state <= STALL;
        end
    end

    a_issue_after_grant: assert property (@(posedge clk) disable iff (reset)
        (state == ISSUE) |-> $past(grant_fire));

    a_count_bound: assert property (@(posedge clk) disable iff (reset)
        count <= CNT_W'(MAX_OUT));

endmodule

// File: tb/tb_vreg_port_arbiter.sv
// Self-checking bench for vreg_port_arbiter: directed scenarios plus randomized traffic
// compared each cycle with a queue-based reference model.
`timescale 1ns/1ps
module tb_vreg_port_arbiter;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int IW = 5;
    localparam int MO = 4;
    localparam int SL = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_vld;
    logic [N-1:0]      req_we;
    logic [IW-1:0]     r_idx [N];
    logic [DW-1:0]     r_wdata [N];
    logic [N*IW-1:0]   req_idx;
    logic [N*DW-1:0]   req_wdata;
    logic [N-1:0]      req_grant;
    logic [N-1:0]      rsp_vld;
    logic [DW-1:0]     rsp_data;
    logic              rf_vld;
    logic              rf_we;
    logic [IW-1:0]     rf_idx;
    logic [DW-1:0]     rf_wdata;
    logic              rf_ready;
    logic              rf_rsp_vld;
    logic [DW-1:0]     rf_rsp_data;
    logic              err_orphan;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_idx[i*IW +: IW]   = r_idx[i];
            req_wdata[i*DW +: DW] = r_wdata[i];
        end
    end

    vreg_port_arbiter #(
        .NUM_REQ(N), .DATA_W(DW), .IDX_W(IW), .MAX_OUT(MO), .STARVE_LIM(SL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_vld     (req_vld),
        .req_we      (req_we),
        .req_idx     (req_idx),
        .req_wdata   (req_wdata),
        .req_grant   (req_grant),
        .rsp_vld     (rsp_vld),
        .rsp_data    (rsp_data),
        .rf_vld      (rf_vld),
        .rf_we       (rf_we),
        .rf_idx      (rf_idx),
        .rf_wdata    (rf_wdata),
        .rf_ready    (rf_ready),
        .rf_rsp_vld  (rf_rsp_vld),
        .rf_rsp_data (rf_rsp_data),
        .err_orphan  (err_orphan)
    );

    typedef struct packed {
        int          due;
        logic [63:0] data;
    } ret_t;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          m_ptr = 0;
    int          m_q[$];
    bit          m_err = 1'b0;
    logic [3:0]  m_rsp = '0;
    logic [63:0] m_data = '0;
    int          m_starve = 0;
    ret_t        ret_q[$];
    int          lat = 2;
    bit          rsp_en = 1'b1;
    bit          force_rsp = 1'b0;
    bit          pend [N];
    int          gnt_log[$];
    int          gnt_cyc[$];
    int          rsp_log[$];
    int          rsp_cyc[$];

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    function automatic int firstFrom(input logic [N-1:0] mask);
        for (int k = 0; k < N; k++) begin
            if (mask[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic int pickWinner(input logic [N-1:0] elig);
`ifdef VREG_ARB_WR_PRIO_EN
        int rd;
        int wr;
        rd = firstFrom(elig & ~req_we);
        wr = firstFrom(elig & req_we);
        if (rd >= 0 && m_starve >= SL) return rd;
        if (wr >= 0) return wr;
        return rd;
`else
        return firstFrom(elig);
`endif
    endfunction

    function automatic int lastGrant();
        return (gnt_log.size() > 0) ? gnt_log[gnt_log.size() - 1] : 0;
    endfunction

    task automatic clearLogs();
        gnt_log.delete();
        gnt_cyc.delete();
        rsp_log.delete();
        rsp_cyc.delete();
    endtask

    // One clock: present the register-file return, check everything, then advance the model.
    task automatic stepCycle();
        int         w;
        bit         full;
        logic [N-1:0] elig;
        logic [N-1:0] expg;
        ret_t       r;
        rf_rsp_vld  = force_rsp || (rsp_en && ret_q.size() > 0 && ret_q[0].due <= cyc);
        rf_rsp_data = force_rsp ? {$urandom, $urandom} : (rf_rsp_vld ? ret_q[0].data : '0);
        #1;
        full = (m_q.size() >= MO) && !rf_rsp_vld;
        elig = '0;
        if (!reset) begin
            for (int i = 0; i < N; i++) elig[i] = req_vld[i] && (req_we[i] || !full);
        end
        w    = pickWinner(elig);
        expg = (w >= 0 && rf_ready) ? 4'(1 << w) : '0;
        checkOutput("rf_vld", rf_vld, (elig != '0));
        checkOutput("req_grant", req_grant, expg);
        if (w >= 0) begin
            checkOutput("rf_we", rf_we, req_we[w]);
            checkOutput("rf_idx", rf_idx, r_idx[w]);
            checkOutput("rf_wdata", rf_wdata, r_wdata[w]);
        end
        checkOutput("rsp_vld", rsp_vld, m_rsp);
        checkOutput("rsp_data", rsp_data, m_data);
        checkOutput("err_orphan", err_orphan, m_err);
        if (req_grant != '0) begin
            gnt_log.push_back(int'(req_grant));
            gnt_cyc.push_back(cyc);
        end
        if (rsp_vld != '0) begin
            rsp_log.push_back(int'(rsp_vld));
            rsp_cyc.push_back(cyc);
        end
        @(posedge clk);
        if (reset) begin
            m_ptr = 0;
            m_q.delete();
            m_err = 1'b0;
            m_rsp = '0;
            m_data = '0;
            m_starve = 0;
        end else begin
            m_rsp = '0;
            if (rf_rsp_vld) begin
                if (m_q.size() > 0) begin
                    m_rsp  = 4'(1 << m_q.pop_front());
                    m_data = rf_rsp_data;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (expg != '0) begin
                m_ptr = (w + 1) % N;
                pend[w] = 1'b0;
                if (!req_we[w]) begin
                    m_q.push_back(w);
                    r.due  = cyc + lat;
                    r.data = {$urandom, $urandom};
                    ret_q.push_back(r);
                    m_starve = 0;
                end else if ((elig & ~req_we) != '0) begin
                    m_starve = (m_starve < SL) ? m_starve + 1 : SL;
                end
            end
        end
        if (rf_rsp_vld && !force_rsp) void'(ret_q.pop_front());
        @(negedge clk);
        cyc++;
    endtask

    task automatic applyStimulus(input logic [N-1:0] vld, input logic [N-1:0] we, input bit ready, input int n);
        req_vld  = vld;
        req_we   = we;
        rf_ready = ready;
        for (int i = 0; i < N; i++) begin
            r_idx[i]   = IW'($urandom);
            r_wdata[i] = {$urandom, $urandom};
        end
        for (int c = 0; c < n; c++) stepCycle();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int first_rd;
        reset       = 1'b1;
        req_vld     = '0;
        req_we      = '0;
        rf_ready    = 1'b0;
        rf_rsp_vld  = 1'b0;
        rf_rsp_data = '0;
        for (int i = 0; i < N; i++) begin
            r_idx[i]   = '0;
            r_wdata[i] = '0;
            pend[i]    = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);

        // Reset held with every requester asking.
        applyStimulus(4'hF, 4'h0, 1'b1, 3);
        checkOutput("reset_grant_log", gnt_log.size(), 0);

        // Fairness with all reads and register-file latency 2.
        reset = 1'b0;
        lat   = 2;
        clearLogs();
        applyStimulus(4'hF, 4'h0, 1'b1, 5);
        applyStimulus(4'h0, 4'h0, 1'b1, 6);
        checkOutput("fair_gnt_cnt", gnt_log.size(), 5);
        checkOutput("fair_rsp_cnt", rsp_log.size(), 5);
        for (int k = 0; k < 5; k++) begin
            if (k < gnt_log.size()) checkOutput("fair_gnt_order", gnt_log[k], (k == 4) ? 1 : (1 << k));
            if (k < 4 && k < rsp_log.size()) checkOutput("fair_rsp_order", rsp_log[k], 1 << k);
            if (k < 4 && k < rsp_log.size() && k < gnt_cyc.size())
                checkOutput("fair_rsp_delay", rsp_cyc[k] - gnt_cyc[k], 3);
        end

        // Backpressure: no grant while rf_ready is low, then immediate grant.
        clearLogs();
        applyStimulus(4'b0100, 4'h0, 1'b0, 5);
        checkOutput("bp_no_grant", gnt_log.size(), 0);
        applyStimulus(4'b0100, 4'h0, 1'b1, 1);
        checkOutput("bp_grant", lastGrant(), 4'b0100);
        applyStimulus(4'h0, 4'h0, 1'b1, 5);

        // Tag FIFO full: reads blocked, writes pass, a same-cycle pop lets a read in.
        clearLogs();
        rsp_en = 1'b0;
        applyStimulus(4'hF, 4'h0, 1'b1, 4);
        checkOutput("full_fill_cnt", gnt_log.size(), 4);
        applyStimulus(4'b0011, 4'b0010, 1'b1, 1);
        checkOutput("full_write_only", lastGrant(), 4'b0010);
        rsp_en = 1'b1;
        applyStimulus(4'b0001, 4'h0, 1'b1, 1);
        checkOutput("full_pop_read", lastGrant(), 4'b0001);
        applyStimulus(4'h0, 4'h0, 1'b1, 8);

        // Orphan response with nothing outstanding.
        clearLogs();
        force_rsp = 1'b1;
        applyStimulus(4'h0, 4'h0, 1'b1, 1);
        force_rsp = 1'b0;
        applyStimulus(4'h0, 4'h0, 1'b1, 10);
        checkOutput("orphan_sticky", err_orphan, 1'b1);
        checkOutput("orphan_no_rsp", rsp_log.size(), 0);

        // Read against a continuous stream of writes.
        reset = 1'b1;
        applyStimulus(4'h0, 4'h0, 1'b1, 2);
        reset = 1'b0;
        clearLogs();
        applyStimulus(4'hF, 4'b1110, 1'b1, 9);
        first_rd = -1;
        for (int k = gnt_log.size() - 1; k >= 0; k--) begin
            if (gnt_log[k] == 1) first_rd = k;
        end
`ifdef VREG_ARB_WR_PRIO_EN
        checkOutput("prio_first_read", first_rd, 8);
`else
        checkOutput("rr_read_within_4", (first_rd >= 0 && first_rd < 4), 1'b1);
`endif
        applyStimulus(4'h0, 4'h0, 1'b1, 6);

        // Randomized traffic, including occasional mid-operation resets.
        for (int c = 0; c < 600; c++) begin
            reset    = ($urandom_range(0, 99) == 0);
            rf_ready = ($urandom_range(0, 3) != 0);
            rsp_en   = ($urandom_range(0, 4) != 0);
            lat      = $urandom_range(1, 4);
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i]    = 1'b1;
                    req_we[i]  = $urandom_range(0, 1) == 1;
                    r_idx[i]   = IW'($urandom);
                    r_wdata[i] = {$urandom, $urandom};
                end
                req_vld[i] = pend[i];
            end
            stepCycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
